// File: rtl/branch_ctrl.sv
// D-stage branch resolution control: detects operand hazards against E/M,
// stalls the exact number of cycles required, then resolves and counts branches.
module branch_ctrl #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_valid,
  input  logic [5:0]       d_op,
  input  logic [4:0]       d_rs,
  input  logic [4:0]       d_rt,
  input  logic             e_regwrite,
  input  logic [4:0]       e_dst,
  input  logic             e_load,
  input  logic             m_regwrite,
  input  logic [4:0]       m_dst,
  input  logic             m_load,
  input  logic             cmp_true,
  output logic             stall_d,
  output logic             br_taken,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] tk_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESOLVE = 2'd2
  } state_t;

  state_t     state, state_nx;
  logic [1:0] cnt, cnt_nx;
  logic       upd;
  logic       is_two_src, is_branch;
  logic [1:0] need_rs, need_rt, need;

  function automatic logic [1:0] src_need(
    input logic [4:0] src,
    input logic       ew, input logic [4:0] ed, input logic el,
    input logic       mw, input logic [4:0] md, input logic ml
  );
    logic [1:0] n;
    n = 2'd0;
    if (src != 5'd0) begin
      if (ew && ed == src)            n = el ? 2'd2 : 2'd1;
      else if (mw && ml && md == src) n = 2'd1;
    end
    return n;
  endfunction

  always_comb begin
    is_two_src = (d_op == 6'b000100) || (d_op == 6'b000101);
    is_branch  = d_valid &&
                 ((d_op[5:2] == 4'b0001) ||
                  ((d_op == 6'b000001) && (d_rt == 5'd0 || d_rt == 5'd1)));
    need_rs = src_need(d_rs, e_regwrite, e_dst, e_load, m_regwrite, m_dst, m_load);
    need_rt = is_two_src ?
              src_need(d_rt, e_regwrite, e_dst, e_load, m_regwrite, m_dst, m_load) : 2'd0;
    need    = (need_rs > need_rt) ? need_rs : need_rt;
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    stall_d  = 1'b0;
    br_taken = 1'b0;
    upd      = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_branch) begin
          case (need)
            2'd0: begin
              br_taken = cmp_true;
              upd      = 1'b1;
            end
            2'd1: begin
              stall_d  = 1'b1;
              state_nx = RESOLVE;
            end
            default: begin
              stall_d  = 1'b1;
              cnt_nx   = 2'd1;
              state_nx = WAIT;
            end
          endcase
        end
      end
      WAIT: begin
        // A D-stage flush abandons the branch outright
        if (!d_valid) begin
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          stall_d = 1'b1;
          cnt_nx  = cnt - 2'd1;
          if (cnt == 2'd1) state_nx = RESOLVE;
        end
      end
      RESOLVE: begin
        state_nx = IDLE;
        if (d_valid) begin
          br_taken = cmp_true;
          upd      = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      tk_cnt <= '0;
    end else if (upd) begin
      if (br_cnt != '1)             br_cnt <= br_cnt + 1'b1;
      if (br_taken && tk_cnt != '1) tk_cnt <= tk_cnt + 1'b1;
    end
  end

endmodule
